// File: rtl/ctrl_sequencer_if.sv
// Control and handshake bundle between the sequencer (master) and the
// instruction memory, instruction register, ALU/RF datapath and data memory (slave).
interface ctrl_sequencer_if #(
    parameter int PC_W = 8
);
    logic            run;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic            IL;
    logic [3:0]      opcode;
    logic [3:0]      DR;
    logic [3:0]      SA;
    logic            alu_zero;
    logic [3:0]      alu_func;
    logic            rf_we;
    logic            rf_src_mem;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;
    logic [PC_W-1:0] pc;
    logic [2:0]      state;
    logic            halted;
    logic            fault;

    modport master (
        input  run, imem_ack, opcode, DR, SA, alu_zero, dmem_ack,
        output imem_req, imem_addr, IL, alu_func, rf_we, rf_src_mem,
               dmem_req, dmem_we, pc, state, halted, fault
    );

    modport slave (
        output run, imem_ack, opcode, DR, SA, alu_zero, dmem_ack,
        input  imem_req, imem_addr, IL, alu_func, rf_we, rf_src_mem,
               dmem_req, dmem_we, pc, state, halted, fault
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle Moore sequencer: owns the PC, fetches over imem req/ack, decodes the
// IR opcode and steers RF write, ALU function, dmem handshake and branch/halt control.
module ctrl_sequencer #(
    parameter int PC_W     = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk_main,
    input  logic             reset,
    ctrl_sequencer_if.master bus
);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t            state_q, state_d;
    state_t            boundary;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fault_q, fault_d;
    logic [3:0]        op_q, op_d;
    logic [PC_W-1:0]   target;
    logic              waited_out;

    assign boundary   = bus.run ? S_FETCH : S_IDLE;
    assign target     = PC_W'({bus.DR, bus.SA});
    // The current no-ack cycle is the WAIT_MAX-th one.
    assign waited_out = (wait_q == WAIT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            wait_q  <= '0;
            fault_q <= 1'b0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE:   if (bus.run) state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ack) begin
                    state_d = S_LOAD;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (waited_out) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            S_LOAD: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d = bus.opcode;
                case (bus.opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state_d = S_EXEC;
                    4'h8, 4'h9: state_d = S_MEM;
                    4'hA: begin
                        pc_d    = target;
                        state_d = boundary;
                    end
                    4'hB: begin
                        if (bus.alu_zero) pc_d = target;
                        state_d = boundary;
                    end
                    4'hF:    state_d = S_HALT;
                    default: state_d = boundary;
                endcase
            end
            S_EXEC:   state_d = boundary;
            S_MEM: begin
                if (bus.dmem_ack) begin
                    state_d = (op_q == 4'h9) ? boundary : S_WB;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (waited_out) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            S_WB:     state_d = boundary;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
        // Each new handshake starts its timeout window from zero.
        if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) wait_d = '0;
    end

    always_comb begin
        bus.imem_req   = (state_q == S_FETCH);
        bus.imem_addr  = (state_q == S_FETCH) ? pc_q : '0;
        bus.IL         = (state_q == S_LOAD);
        bus.alu_func   = (state_q == S_EXEC) ? op_q : 4'h0;
        bus.rf_we      = (state_q == S_EXEC) || (state_q == S_WB);
        bus.rf_src_mem = (state_q == S_WB);
        bus.dmem_req   = (state_q == S_MEM);
        bus.dmem_we    = (state_q == S_MEM) && (op_q == 4'h9);
        bus.halted     = (state_q == S_HALT);
    end

    assign bus.pc    = pc_q;
    assign bus.state = state_q;
    assign bus.fault = fault_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed scenarios plus random programs scored against an
// instruction-level model of fetch/ALU/memory/branch behaviour and per-instruction timing.
module tb_ctrl_sequencer;
    localparam int PC_W     = 8;
    localparam int WAIT_MAX = 15;

    logic clk_main = 1'b0;
    logic reset    = 1'b0;

    ctrl_sequencer_if #(.PC_W(PC_W)) bus ();

    ctrl_sequencer #(.PC_W(PC_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk_main (clk_main),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk_main = ~clk_main;

    typedef struct {
        int kind;   // 0 fetch addr, 1 rf write {src,func}, 2 dmem we, 3 halt fault
        int val;
        int gap;    // cycles since previous fetch handshake, -1 = not checked
    } ev_t;

    logic [15:0] prog [256];
    logic [15:0] idata = '0;
    logic [15:0] ir    = '0;
    ev_t         exp_q[$];
    int          imem_dq[$];
    int          dmem_dq[$];
    int          imem_def = 0;
    int          dmem_def = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_fetch = 0;
    bit          sb_en = 0;
    bit          halt_seen = 0;
    int          final_pc = 0;
    int          i_cnt, i_dly, d_cnt, d_dly;
    bit          i_busy = 0, d_busy = 0;

    assign bus.opcode   = ir[15:12];
    assign bus.DR       = ir[11:8];
    assign bus.SA       = ir[7:4];
    assign bus.alu_zero = ir[0];

    // Instruction memory data and the instruction register
    always @(posedge clk_main) begin
        if (bus.imem_req && bus.imem_ack) idata <= prog[bus.imem_addr];
        if (bus.IL) ir <= idata;
    end

    initial begin : imem_responder
        bus.imem_ack = 1'b0;
        forever begin
            @(posedge clk_main); #1;
            if (bus.imem_req) begin
                if (!i_busy) begin
                    i_busy = 1;
                    i_cnt  = 0;
                    i_dly  = (imem_dq.size() > 0) ? imem_dq.pop_front() : imem_def;
                end
                if (i_cnt == i_dly) begin
                    bus.imem_ack = 1'b1;
                    i_busy = 0;
                end else begin
                    bus.imem_ack = 1'b0;
                    i_cnt++;
                end
            end else begin
                bus.imem_ack = 1'b0;
                i_busy = 0;
            end
        end
    end

    initial begin : dmem_responder
        bus.dmem_ack = 1'b0;
        forever begin
            @(posedge clk_main); #1;
            if (bus.dmem_req) begin
                if (!d_busy) begin
                    d_busy = 1;
                    d_cnt  = 0;
                    d_dly  = (dmem_dq.size() > 0) ? dmem_dq.pop_front() : dmem_def;
                end
                if (d_cnt == d_dly) begin
                    bus.dmem_ack = 1'b1;
                    d_busy = 0;
                end else begin
                    bus.dmem_ack = 1'b0;
                    d_cnt++;
                end
            end else begin
                bus.dmem_ack = 1'b0;
                d_busy = 0;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic sb_check(input int kind, input int val, input int gap);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind=%0d val=%0h, expected no event", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || (e.gap >= 0 && e.gap != gap)) begin
                errors++;
                $display("FAIL sb_event: got kind=%0d val=%0h gap=%0d expected kind=%0d val=%0h gap=%0d",
                         kind, val, gap, e.kind, e.val, e.gap);
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk_main);
            cyc++;
            if (sb_en) begin
                if (bus.imem_req && bus.imem_ack) begin
                    sb_check(0, int'(bus.imem_addr), cyc - last_fetch);
                    last_fetch = cyc;
                end
                if (bus.rf_we) sb_check(1, int'({bus.rf_src_mem, bus.alu_func}), -1);
                if (bus.dmem_req && bus.dmem_ack) sb_check(2, int'(bus.dmem_we), -1);
                if (bus.halted && !halt_seen) begin
                    halt_seen = 1;
                    sb_check(3, int'(bus.fault), -1);
                end
                checks++;
                if ((bus.IL && bus.state != 3'd2) || (bus.rf_we && bus.dmem_req)) begin
                    errors++;
                    $display("FAIL invariant: IL=%0b state=%0d rf_we=%0b dmem_req=%0b, required IL only in LOAD and no rf_we with dmem_req",
                             bus.IL, bus.state, bus.rf_we, bus.dmem_req);
                end
            end
        end
    end

    task automatic push_ev(input int kind, input int val, input int gap);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_state(input int s, input int max, input string name);
        int k = 0;
        while (int'(bus.state) != s && k < max) begin
            @(negedge clk_main);
            k++;
        end
        if (int'(bus.state) != s) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out, state %0d required %0d", name, bus.state, s);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_main);
        sb_en = 0;
        bus.run = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        imem_dq.delete();
        dmem_dq.delete();
        imem_def = 0;
        dmem_def = 0;
        halt_seen = 0;
        for (int a = 0; a < 256; a++) prog[a] = 16'hF000;
        @(negedge clk_main);
        @(negedge clk_main);
        reset = 1'b1;
    endtask

    // Instruction-level model: walks the program, choosing handshake delays and
    // predicting the observable event stream and the spacing between fetches.
    task automatic build_random();
        bit fetched [256];
        int pc, nxt, n, op, di, dm, extra;
        bit done;
        done = 0;
        while (!done) begin
            exp_q.delete();
            imem_dq.delete();
            dmem_dq.delete();
            for (int a = 0; a < 256; a++) begin
                fetched[a] = 0;
                prog[a] = {4'($urandom_range(0, 14)), 12'($urandom)};
            end
            pc = 0;
            n = 0;
            extra = 0;
            while (!done && n < 1000) begin
                if (n >= 80 && !fetched[pc]) prog[pc] = 16'hF000;
                di = ($urandom_range(0, 9) == 0) ? WAIT_MAX - 1 : $urandom_range(0, 3);
                imem_dq.push_back(di);
                push_ev(0, pc, (n == 0) ? -1 : extra + 3 + di);
                fetched[pc] = 1;
                op = int'(prog[pc][15:12]);
                nxt = (pc + 1) % 256;
                extra = 0;
                if (op >= 1 && op <= 7) begin
                    push_ev(1, op, -1);
                    extra = 1;
                end else if (op == 8 || op == 9) begin
                    dm = ($urandom_range(0, 9) == 0) ? WAIT_MAX - 1 : $urandom_range(0, 3);
                    dmem_dq.push_back(dm);
                    push_ev(2, (op == 9) ? 1 : 0, -1);
                    if (op == 8) begin
                        push_ev(1, 16, -1);
                        extra = dm + 2;
                    end else begin
                        extra = dm + 1;
                    end
                end else if (op == 10 || (op == 11 && prog[pc][0])) begin
                    nxt = int'(prog[pc][11:4]);
                end else if (op == 15) begin
                    push_ev(3, 0, -1);
                    done = 1;
                end
                pc = nxt;
                n++;
            end
        end
        final_pc = pc;
    endtask

    int exp_seq [8] = '{1, 2, 3, 4, 1, 2, 3, 7};
    int k, we_cnt, rf_cnt;

    initial begin
        bus.run = 1'b0;
        for (int a = 0; a < 256; a++) prog[a] = 16'hF000;

        // Reset state
        @(negedge clk_main);
        chk("reset_state", int'(bus.state), 0);
        chk("reset_pc", int'(bus.pc), 0);
        chk("reset_outputs", int'({bus.imem_req, bus.IL, bus.rf_we, bus.rf_src_mem, bus.dmem_req,
                                   bus.dmem_we, bus.halted, bus.fault, bus.alu_func, bus.imem_addr}), 0);

        // ALU instruction with immediate acks
        do_reset();
        prog[0] = 16'h1123;
        bus.run = 1'b1;
        rf_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_main);
            chk("alu_state_seq", int'(bus.state), exp_seq[i]);
            if (bus.rf_we) begin
                rf_cnt++;
                chk("alu_func", int'(bus.alu_func), 1);
                chk("alu_rf_src", int'(bus.rf_src_mem), 0);
            end
            if (i == 4) chk("alu_pc", int'(bus.pc), 1);
        end
        chk("alu_rf_we_cycles", rf_cnt, 1);

        // JMP
        do_reset();
        prog[0] = 16'hA050;
        bus.run = 1'b1;
        wait_state(3, 10, "jmp_decode");
        @(negedge clk_main);
        chk("jmp_pc", int'(bus.pc), 5);
        chk("jmp_fetch_addr", int'(bus.imem_addr), 5);

        // BZ not taken / taken
        do_reset();
        prog[0] = 16'hB0A0;
        bus.run = 1'b1;
        wait_state(3, 10, "bz0_decode");
        @(negedge clk_main);
        chk("bz_not_taken_pc", int'(bus.pc), 1);
        do_reset();
        prog[0] = 16'hB0A1;
        bus.run = 1'b1;
        wait_state(3, 10, "bz1_decode");
        @(negedge clk_main);
        chk("bz_taken_pc", int'(bus.pc), 8'h0A);

        // LD with dmem ack delayed 3 cycles
        do_reset();
        prog[0] = 16'h8000;
        dmem_def = 3;
        bus.run = 1'b1;
        wait_state(5, 10, "ld_mem");
        k = 0;
        we_cnt = 0;
        while (bus.dmem_req && k < 20) begin
            if (bus.dmem_we) we_cnt++;
            k++;
            @(negedge clk_main);
        end
        chk("ld_req_cycles", k, 4);
        chk("ld_we_cycles", we_cnt, 0);
        chk("ld_wb_state", int'(bus.state), 6);
        chk("ld_wb_rf", int'({bus.rf_we, bus.rf_src_mem}), 3);

        // Fetch timeout
        do_reset();
        imem_def = 1000;
        bus.run = 1'b1;
        @(negedge clk_main);
        k = 0;
        while (bus.state == 3'd1 && k < 40) begin
            k++;
            @(negedge clk_main);
        end
        chk("timeout_fetch_cycles", k, WAIT_MAX);
        chk("timeout_fault", int'(bus.fault), 1);
        chk("timeout_halted", int'(bus.halted), 1);
        repeat (10) @(negedge clk_main);
        chk("timeout_stays_halt", int'(bus.state), 7);

        // run dropped during a store
        do_reset();
        prog[0] = 16'h9000;
        dmem_def = 2;
        bus.run = 1'b1;
        wait_state(5, 10, "st_mem");
        chk("st_dmem_we", int'(bus.dmem_we), 1);
        bus.run = 1'b0;
        k = 0;
        while (bus.state == 3'd5 && k < 20) begin
            k++;
            @(negedge clk_main);
        end
        chk("st_to_idle", int'(bus.state), 0);
        chk("st_pc", int'(bus.pc), 1);
        repeat (2) @(negedge clk_main);
        chk("st_idle_hold", int'(bus.state), 0);
        bus.run = 1'b1;
        @(negedge clk_main);
        chk("st_resume_state", int'(bus.state), 1);
        chk("st_resume_addr", int'(bus.imem_addr), 1);

        // PC wrap at 0xFF
        do_reset();
        prog[0] = 16'hAFF0;
        prog[8'hFF] = 16'h1000;
        bus.run = 1'b1;
        wait_state(4, 20, "wrap_exec");
        chk("wrap_pc", int'(bus.pc), 0);
        @(negedge clk_main);
        chk("wrap_fetch_addr", int'(bus.imem_addr), 0);

        // Asynchronous reset in the middle of a load
        do_reset();
        prog[0] = 16'h8000;
        dmem_def = 1000;
        bus.run = 1'b1;
        wait_state(5, 10, "rst_mem");
        chk("rst_mem_req_before", int'(bus.dmem_req), 1);
        #1 reset = 1'b0;
        #1;
        chk("rst_mem_req_after", int'(bus.dmem_req), 0);
        chk("rst_mem_pc", int'(bus.pc), 0);
        chk("rst_mem_state", int'(bus.state), 0);
        bus.run = 1'b0;
        @(negedge clk_main);
        reset = 1'b1;
        repeat (3) @(negedge clk_main);
        chk("rst_mem_idle", int'(bus.state), 0);

        // Random programs against the instruction-level model
        for (int r = 0; r < 3; r++) begin
            do_reset();
            build_random();
            last_fetch = cyc;
            sb_en = 1;
            bus.run = 1'b1;
            k = 0;
            while (!bus.halted && k < 30000) begin
                @(negedge clk_main);
                k++;
            end
            @(negedge clk_main);
            sb_en = 0;
            chk("rand_halted", int'(bus.halted), 1);
            chk("rand_events_left", exp_q.size(), 0);
            chk("rand_final_pc", int'(bus.pc), final_pc);
            chk("rand_fault", int'(bus.fault), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
